// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback port arbiter with a CLEAR sequencer for r1..r31.
// Round-robin by default; define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata
);

    localparam int PW = $clog2(NREQ);
    localparam logic [AW-1:0] LAST_ADDR = AW'(31);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, w_ptr_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_waddr, w_waddr_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;
    logic            r_done, w_done_nxt;
    logic [NREQ-1:0] w_ack;

    logic [PW-1:0]   w_scan [NREQ];
    logic            w_gnt_any;
    logic [PW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // First valid requester scanning upward from the round-robin pointer.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan[k] = PW'((32'(r_rr_ptr) + 32'(k)) % NREQ);
            if (!w_gnt_any && req_valid[w_scan[k]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan[k];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_rr_ptr;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_done_nxt  = 1'b0;
        w_ack       = '0;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = AW'(1);
                    w_wdata_nxt = '0;
                end else if (w_gnt_any) begin
                    w_ack[w_gnt_idx] = 1'b1;
                    // r0 is hardwired: accept the request but suppress the write.
                    w_we_nxt    = (w_sel_addr != '0);
                    w_waddr_nxt = w_sel_addr;
                    w_wdata_nxt = w_sel_data;
`ifdef WB_ARB_FIXED_PRIO_EN
                    w_ptr_nxt   = '0;
`else
                    w_ptr_nxt   = (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
`endif
                end
            end
            S_CLEAR: begin
                if (r_waddr == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_waddr + 1'b1;
                    w_wdata_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_ptr_nxt;
            r_we     <= w_we_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign req_ack  = rst ? '0 : w_ack;
    assign clr_busy = (r_state == S_CLEAR);
    assign clr_done = r_done;
    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected write-port values are queued when a
// request or clear step is driven and compared after the posedge that should load them.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ack;
    logic               clr_start, clr_busy, clr_done, rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;

    logic [DW-1:0] mem [32];
    wr_t           exp_q [$];
    wr_t           e;
    int            checks = 0;
    int            errors = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ack(req_ack), .clr_start(clr_start),
        .clr_busy(clr_busy), .clr_done(clr_done), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Regfile model stores any address, so a stray r0 write would be visible.
    always @(negedge clk) if (rf_we) mem[rf_waddr] <= rf_wdata;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req_valid = '0; clr_start = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [NREQ-1:0] exp_ack [2];
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clr_start = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, clr_busy, clr_done, req_ack} !== '0) begin
            errors++;
            $display("FAIL reset_vals got we=%b a=%h d=%h busy=%b done=%b ack=%b exp all 0",
                     rf_we, rf_waddr, rf_wdata, clr_busy, clr_done, req_ack);
        end
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'(16 + i);
            req_data[i*DW +: DW] = 32'h5000 + i;
        end
        req_valid = '1;
`ifdef WB_ARB_FIXED_PRIO_EN
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b001;
`else
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b010;
`endif
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (req_ack !== exp_ack[k]) begin
                errors++;
                $display("FAIL pre_reset_ack%0d got %b exp %b", k, req_ack, exp_ack[k]);
            end
            tick();
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({rf_we, req_ack, clr_busy, rf_waddr} !== '0) begin
            errors++;
            $display("FAIL midstream_reset got we=%b ack=%b busy=%b a=%h exp 0",
                     rf_we, req_ack, clr_busy, rf_waddr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ack !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_first_grant got %b exp 001", req_ack);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single_write;
        do_reset();
        req_addr[1*AW +: AW] = 5'd5;
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        req_valid = 3'b010;
        #1;
        checks++;
        if (req_ack !== 3'b010) begin
            errors++;
            $display("FAIL single_ack got %b exp 010", req_ack);
        end
        exp_q.push_back('{1'b1, 5'd5, 32'hDEADBEEF});
        tick();
        req_valid = '0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL single_sb got empty exp entry");
        end else begin
            e = exp_q.pop_front();
            if ({rf_we, rf_waddr, rf_wdata} !== e) begin
                errors++;
                $display("FAIL single_wr got %b/%h/%h exp %b/%h/%h",
                         rf_we, rf_waddr, rf_wdata, e.we, e.a, e.d);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_r5 got %h exp deadbeef", mem[5]);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || req_ack !== '0) begin
            errors++;
            $display("FAIL single_pulse got we=%b ack=%b exp 0/000", rf_we, req_ack);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] win [6];
        logic [1:0] win2 [3];
`ifdef WB_ARB_FIXED_PRIO_EN
        win  = '{0, 0, 0, 0, 0, 0};
        win2 = '{0, 0, 0};
`else
        win  = '{0, 1, 2, 0, 1, 2};
        win2 = '{0, 2, 0};
`endif
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'(8 + i);
            req_data[i*DW +: DW] = 32'hA000 + i;
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req_ack !== (3'b001 << win[k])) begin
                errors++;
                $display("FAIL rr_ack%0d got %b exp %b", k, req_ack, 3'b001 << win[k]);
            end
            exp_q.push_back('{1'b1, AW'(8 + win[k]), 32'hA000 + win[k]});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== e) begin
                errors++;
                $display("FAIL rr_wr%0d got %b/%h/%h exp %b/%h/%h",
                         k, rf_we, rf_waddr, rf_wdata, e.we, e.a, e.d);
            end
        end
        // Skipping a non-valid requester.
        do_reset();
        req_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ack !== (3'b001 << win2[k])) begin
                errors++;
                $display("FAIL rr_skip_ack%0d got %b exp %b", k, req_ack, 3'b001 << win2[k]);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_zero_addr;
        do_reset();
        req_addr[0 +: AW] = '0;
        req_data[0 +: DW] = 32'h1234;
        req_valid = 3'b001;
        #1;
        checks++;
        if (req_ack !== 3'b001) begin
            errors++;
            $display("FAIL zero_ack got %b exp 001", req_ack);
        end
        exp_q.push_back('{1'b0, 5'd0, 32'h1234});
        tick();
        req_valid = '0;
        e = exp_q.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== e) begin
            errors++;
            $display("FAIL zero_wr got %b/%h/%h exp %b/%h/%h",
                     rf_we, rf_waddr, rf_wdata, e.we, e.a, e.d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[0] === 32'h1234) begin
            errors++;
            $display("FAIL zero_r0 got %h exp not 00001234", mem[0]);
        end
    endtask

    task automatic test_clear;
        do_reset();
        req_addr[0 +: AW] = 5'd7;
        req_data[0 +: DW] = 32'hA5A5A5A5;
        req_valid = 3'b001;
        tick();
        req_valid = 3'b100;
        req_addr[2*AW +: AW] = 5'd20;
        req_data[2*DW +: DW] = 32'hCAFE;
        clr_start = 1'b1;
        #1;
        checks++;
        if (req_ack !== '0) begin
            errors++;
            $display("FAIL clr_start_prio got %b exp 000", req_ack);
        end
        exp_q.push_back('{1'b1, 5'd1, 32'h0});
        tick();
        clr_start = 1'b0;
        for (int a = 1; a <= 31; a++) begin
            #1;
            checks++;
            if (req_ack !== '0 || clr_busy !== 1'b1 || clr_done !== 1'b0) begin
                errors++;
                $display("FAIL clr_ctl%0d got ack=%b busy=%b done=%b exp 000/1/0",
                         a, req_ack, clr_busy, clr_done);
            end
            e = exp_q.pop_front();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== e) begin
                errors++;
                $display("FAIL clr_wr%0d got %b/%h/%h exp %b/%h/%h",
                         a, rf_we, rf_waddr, rf_wdata, e.we, e.a, e.d);
            end
            clr_start = (a == 5);
            exp_q.push_back(a < 31 ? '{1'b1, AW'(a + 1), 32'h0} : '{1'b0, 5'd31, 32'h0});
            tick();
        end
        clr_start = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== e || clr_done !== 1'b1 || clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_done_cyc got we=%b a=%h done=%b busy=%b exp 0/1f/1/0",
                     rf_we, rf_waddr, clr_done, clr_busy);
        end
        checks++;
        if (req_ack !== 3'b100) begin
            errors++;
            $display("FAIL clr_done_ack got %b exp 100", req_ack);
        end
        exp_q.push_back('{1'b1, 5'd20, 32'hCAFE});
        tick();
        req_valid = '0;
        e = exp_q.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== e || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL clr_after got %b/%h/%h done=%b exp %b/%h/%h done=0",
                     rf_we, rf_waddr, rf_wdata, clr_done, e.we, e.a, e.d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[7] !== 32'h0 || mem[20] !== 32'hCAFE) begin
            errors++;
            $display("FAIL clr_mem got r7=%h r20=%h exp 0/cafe", mem[7], mem[20]);
        end
    endtask

    task automatic test_reset_clear;
        logic bad;
        do_reset();
        req_valid = 3'b001;
        for (int i = 1; i <= 31; i++) begin
            req_addr[0 +: AW] = AW'(i);
            req_data[0 +: DW] = 32'h11110000 + i;
            #1;
            checks++;
            if (req_ack !== 3'b001) begin
                errors++;
                $display("FAIL preload_ack%0d got %b exp 001", i, req_ack);
            end
            tick();
        end
        req_valid = 3'b100;
        req_addr[2*AW +: AW] = 5'd1;
        req_data[2*DW +: DW] = 32'h33;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int a = 1; a < 10; a++) tick();
        checks++;
        if (rf_waddr !== 5'd10 || clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL rclr_at10 got a=%h busy=%b exp 0a/1", rf_waddr, clr_busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || rf_we !== 1'b0 || req_ack !== '0) begin
            errors++;
            $display("FAIL rclr_reset got busy=%b we=%b ack=%b exp 0/0/000",
                     clr_busy, rf_we, req_ack);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ack !== 3'b100) begin
            errors++;
            $display("FAIL rclr_rearb got %b exp 100", req_ack);
        end
        exp_q.push_back('{1'b1, 5'd1, 32'h33});
        tick();
        req_valid = '0;
        e = exp_q.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== e || clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL rclr_wr got %b/%h/%h busy=%b exp %b/%h/%h busy=0",
                     rf_we, rf_waddr, rf_wdata, clr_busy, e.we, e.a, e.d);
        end
        tick();
        tick();
        bad = (mem[1] !== 32'h33);
        for (int i = 2; i <= 9; i++) if (mem[i] !== 32'h0) bad = 1'b1;
        for (int i = 10; i <= 31; i++) if (mem[i] !== 32'h11110000 + i) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rclr_mem got r2=%h r10=%h r11=%h r31=%h exp 0/1111000a/1111000b/1111001f",
                     mem[2], mem[10], mem[11], mem[31]);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_addr();
        test_clear();
        test_reset_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
